// File: rtl/booth_issue_ctrl_pkg.sv
// Shared definitions for the Booth multiplier issue controller:
// FSM state encoding and default sizing/timing constants.
package booth_issue_ctrl_pkg;

   // Default operand width in bits.
   localparam int N_DEF         = 32;
   // Default operand FIFO depth (power of two, at least 2).
   localparam int DEPTH_DEF     = 4;
   // Default number of cycles mul_start stays high.
   localparam int START_CYC_DEF = 2;
   // Default cycles from mul_start falling to a stable product.
   localparam int MUL_LAT_DEF   = 34;

   // Issue FSM states; the encoding is fixed and shared with debug tooling.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage : booth_issue_ctrl_pkg

// File: rtl/booth_operand_fifo.sv
// Synchronous operand-pair FIFO. Pointers wrap naturally because DEPTH is
// a power of two; push is ignored when full and pop is ignored when empty.
module booth_operand_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4,
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  wdata_i,
   output logic [W-1:0]  rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push_s;
   logic          do_pop_s;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == CW'(0));
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;

   // Storage array: write the incoming pair at the write pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {W{1'b0}};
         end
      end else if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= PW'(0);
         rd_ptr_q <= PW'(0);
         count_q  <= CW'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule : booth_operand_fifo

// File: rtl/booth_issue_ctrl.sv
// Operand-issue stage for a sequential Booth multiplier. Buffers operand
// pairs, launches one multiply at a time with a timed start pulse, waits the
// fixed multiplier latency and presents the captured product on a
// valid/ready port together with its operands.
module booth_issue_ctrl
   import booth_issue_ctrl_pkg::*;
#(
   parameter int N         = N_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int START_CYC = START_CYC_DEF,
   parameter int MUL_LAT   = MUL_LAT_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           enable,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic [N-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   output logic           mul_start,
   output logic           mul_enable,
   input  logic [2*N-1:0] mul_product,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_product,
   output logic [N-1:0]   out_a,
   output logic [N-1:0]   out_b,
   output logic           busy
);

   localparam int CW      = $clog2(DEPTH + 1);
   localparam int CTR_MAX = (START_CYC > MUL_LAT) ? START_CYC : MUL_LAT;
   localparam int CTR_W   = $clog2(CTR_MAX + 1);

   state_e           state_q;
   logic [CTR_W-1:0] ctr_q;
   logic             in_ready_q;
   logic             in_ready_d;
   logic [N-1:0]     mul_a_q;
   logic [N-1:0]     mul_b_q;
   logic             mul_start_q;
   logic             out_valid_q;
   logic [2*N-1:0]   out_product_q;
   logic [N-1:0]     out_a_q;
   logic [N-1:0]     out_b_q;

   logic             push_s;
   logic             pop_s;
   logic [2*N-1:0]   fifo_rdata_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [CW-1:0]    fifo_count_s;
   logic [CW-1:0]    count_d;

   // Push ignores enable; the full check is redundant with in_ready but
   // keeps the FIFO safe if the two ever diverge.
   assign push_s = in_valid && in_ready_q && !fifo_full_s;
   // Pops happen only from IDLE while the FSM is allowed to advance.
   assign pop_s  = enable && (state_q == ST_IDLE) && !fifo_empty_s;

   // Occupancy after this edge; in_ready is registered from it so a pop in
   // the same cycle as a full FIFO never lets a push bypass.
   assign count_d    = fifo_count_s + (push_s ? CW'(1) : CW'(0))
                                    - (pop_s  ? CW'(1) : CW'(0));
   assign in_ready_d = (count_d != CW'(DEPTH));

   booth_operand_fifo #(
      .W     (2 * N),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .wdata_i ({in_a, in_b}),
      .rdata_o (fifo_rdata_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   // Registered ready: low during reset, high one edge after release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= in_ready_d;
      end
   end

   // Issue FSM with registered multiplier drive and result port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         ctr_q         <= CTR_W'(0);
         mul_a_q       <= {N{1'b0}};
         mul_b_q       <= {N{1'b0}};
         mul_start_q   <= 1'b0;
         out_valid_q   <= 1'b0;
         out_product_q <= {(2 * N){1'b0}};
         out_a_q       <= {N{1'b0}};
         out_b_q       <= {N{1'b0}};
      end else begin
         // The output handshake completes even while the FSM is frozen.
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (enable) begin
            case (state_q)
               ST_IDLE: begin
                  if (!fifo_empty_s) begin
                     mul_a_q     <= fifo_rdata_s[2*N-1:N];
                     mul_b_q     <= fifo_rdata_s[N-1:0];
                     out_a_q     <= fifo_rdata_s[2*N-1:N];
                     out_b_q     <= fifo_rdata_s[N-1:0];
                     mul_start_q <= 1'b1;
                     ctr_q       <= CTR_W'(0);
                     state_q     <= ST_LAUNCH;
                  end
               end
               ST_LAUNCH: begin
                  if (ctr_q == CTR_W'(START_CYC - 1)) begin
                     mul_start_q <= 1'b0;
                     ctr_q       <= CTR_W'(0);
                     state_q     <= ST_WAIT;
                  end else begin
                     ctr_q <= ctr_q + CTR_W'(1);
                  end
               end
               ST_WAIT: begin
                  if (ctr_q == CTR_W'(MUL_LAT - 1)) begin
                     out_product_q <= mul_product;
                     out_valid_q   <= 1'b1;
                     ctr_q         <= CTR_W'(0);
                     state_q       <= ST_DONE;
                  end else begin
                     ctr_q <= ctr_q + CTR_W'(1);
                  end
               end
               ST_DONE: begin
                  // Leave once the result is taken (now or while frozen).
                  if (!out_valid_q || out_ready) begin
                     state_q <= ST_IDLE;
                  end
               end
               default: begin
                  state_q     <= ST_IDLE;
                  mul_start_q <= 1'b0;
                  ctr_q       <= CTR_W'(0);
               end
            endcase
         end
      end
   end

   assign in_ready    = in_ready_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign mul_start   = mul_start_q;
   assign mul_enable  = enable;
   assign out_valid   = out_valid_q;
   assign out_product = out_product_q;
   assign out_a       = out_a_q;
   assign out_b       = out_b_q;
   assign busy        = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule : booth_issue_ctrl

// File: tb/tb_booth_issue_ctrl.sv
// Self-checking bench for booth_issue_ctrl. A behavioural stand-in for the
// sequential Booth multiplier answers start pulses with a fixed latency;
// results are scored in order against a queue of expected products.
module tb_booth_issue_ctrl;

   localparam int N         = 32;
   localparam int START_CYC = 2;
   localparam int MUL_LAT   = 34;
   localparam int LAT       = 1 + START_CYC + MUL_LAT;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [N-1:0]  in_a = '0;
   logic [N-1:0]  in_b = '0;
   logic          in_ready;
   logic [N-1:0]  mul_a;
   logic [N-1:0]  mul_b;
   logic          mul_start;
   logic          mul_enable;
   logic [63:0]   mul_product;
   logic          out_valid;
   logic [63:0]   out_product;
   logic [N-1:0]  out_a;
   logic [N-1:0]  out_b;
   logic          busy;

   booth_issue_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_start   (mul_start),
      .mul_enable  (mul_enable),
      .mul_product (mul_product),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .out_a       (out_a),
      .out_b       (out_b),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
   } op_t;

   op_t exp_q[$];
   int  rise_q[$];
   int  last_accept = 0;
   logic prev_valid = 1'b0;
   bit  rand_done = 1'b0;

   // Single comparison point for the whole bench.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Signed 32x32 -> 64 product in plain arithmetic.
   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
      return sa * sb;
   endfunction

   // Multiplier stand-in: garbage while started, correct product exactly
   // MUL_LAT enabled cycles after mul_start falls, frozen by mul_enable.
   int   m_cnt;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cnt       <= 0;
         mul_product <= 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (mul_enable) begin
         if (mul_start) begin
            m_cnt       <= 0;
            mul_product <= 64'hBAD0_BAD0_BAD0_BAD0;
         end else begin
            if (m_cnt == MUL_LAT - 2) mul_product <= ref_mul(mul_a, mul_b);
            if (m_cnt < MUL_LAT) m_cnt <= m_cnt + 1;
         end
      end
   end

   // Result monitor: scores every handshake in order, logs rising edges.
   op_t mon_op;
   always @(negedge clk) begin
      if (reset) begin
         if (out_valid && !prev_valid) rise_q.push_back(cyc);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_result", 64'd1, 64'd0);
            end else begin
               mon_op = exp_q.pop_front();
               check("out_product", out_product, mon_op.p);
               check("out_a", {32'd0, out_a}, {32'd0, mon_op.a});
               check("out_b", {32'd0, out_b}, {32'd0, mon_op.b});
            end
         end
      end
      prev_valid <= out_valid;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
      int guard;
      guard = 0;
      in_a = a;
      in_b = b;
      in_valid = 1'b1;
      while (!in_ready && guard < 3000) begin
         tick(1);
         guard++;
      end
      if (!in_ready) begin
         check("push_timeout", 64'd0, 64'd1);
         in_valid = 1'b0;
      end else begin
         tick(1);
         last_accept = cyc;
         exp_q.push_back('{a: a, b: b, p: p});
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain(input int limit);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < limit) begin
         tick(1);
         guard++;
      end
      check("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0000;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   int a1;
   logic [31:0] ra;
   logic [31:0] rb;

   initial begin
      // Reset state.
      enable = 1'b1;
      tick(3);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_mul_start", {63'd0, mul_start}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_out_product", out_product, 64'd0);
      reset = 1'b1;
      tick(1);
      check("in_ready_after_release", {63'd0, in_ready}, 64'd1);

      // Single operation: exact latency and product.
      out_ready = 1'b1;
      rise_q.delete();
      push(32'h0008_7234, 32'h0000_0348, 64'h0000_0000_1BB6_BAA0);
      wait_drain(200);
      check("single_rises", 64'(rise_q.size()), 64'd1);
      if (rise_q.size() >= 1) check("single_latency", 64'(rise_q[0] - last_accept), 64'(LAT));
      tick(1);
      check("idle_busy", {63'd0, busy}, 64'd0);

      // Signed mix, back-to-back, spacing of one full issue period.
      rise_q.delete();
      push(32'h5064_7236, 32'hB887_CAAF, 64'hE98E_647F_4142_AEEA);
      a1 = last_accept;
      push(32'hFFFF_FEFD, 32'h0008_7234, 64'hFFFF_FFFF_F774_7564);
      wait_drain(300);
      check("mix_rises", 64'(rise_q.size()), 64'd2);
      if (rise_q.size() >= 2) begin
         check("mix_first_latency", 64'(rise_q[0] - a1), 64'(LAT));
         check("mix_spacing", 64'(rise_q[1] - rise_q[0]), 64'(START_CYC + MUL_LAT + 2));
      end

      // Full FIFO with back-pressure: one op in flight plus four buffered.
      out_ready = 1'b0;
      push(32'hFFFF_FEFD, 32'hFFFF_FEFD, 64'h0000_0000_0001_0609);
      push(32'h0000_0001, 32'h5064_7236, 64'h0000_0000_5064_7236);
      push(32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000);
      push(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      push(32'hFFFF_FFFF, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFF9);
      check("full_in_ready", {63'd0, in_ready}, 64'd0);
      check("full_busy", {63'd0, busy}, 64'd1);
      in_a = 32'h0000_0003;
      in_b = 32'hFFFF_FFFE;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("full_rejects", {63'd0, in_ready}, 64'd0);
      end
      check("full_queue_len", 64'(exp_q.size()), 64'd5);
      out_ready = 1'b1;
      push(32'h0000_0003, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA);
      wait_drain(400);

      // Enable freeze during WAIT delays the result by exactly the freeze.
      rise_q.delete();
      push(32'h1357_9BDF, 32'hECA8_6420, ref_mul(32'h1357_9BDF, 32'hECA8_6420));
      tick(15);
      enable = 1'b0;
      tick(10);
      enable = 1'b1;
      wait_drain(200);
      check("freeze_rises", 64'(rise_q.size()), 64'd1);
      if (rise_q.size() >= 1) check("freeze_latency", 64'(rise_q[0] - last_accept), 64'(LAT + 10));

      // Reset mid-WAIT abandons the operation.
      push(32'h1234_5678, 32'h9ABC_DEF0, ref_mul(32'h1234_5678, 32'h9ABC_DEF0));
      tick(20);
      reset = 1'b0;
      #1;
      check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_mul_start", {63'd0, mul_start}, 64'd0);
      check("midrst_mul_a", {32'd0, mul_a}, 64'd0);
      check("midrst_mul_b", {32'd0, mul_b}, 64'd0);
      check("midrst_out_product", out_product, 64'd0);
      check("midrst_out_a", {32'd0, out_a}, 64'd0);
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
      exp_q.delete();
      rise_q.delete();
      tick(2);
      reset = 1'b1;
      tick(60);
      check("post_rst_no_result", 64'(rise_q.size()), 64'd0);
      check("post_rst_busy", {63'd0, busy}, 64'd0);
      push(32'hB887_CAAF, 32'h0000_0001, 64'hFFFF_FFFF_B887_CAAF);
      wait_drain(200);

      // Hold in DONE while the consumer stalls.
      out_ready = 1'b0;
      push(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
      begin
         int g;
         g = 0;
         while (!out_valid && g < 100) begin
            tick(1);
            g++;
         end
      end
      check("hold_reached", {63'd0, out_valid}, 64'd1);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("hold_valid", {63'd0, out_valid}, 64'd1);
         check("hold_product", out_product, 64'hC000_0000_8000_0000);
         check("hold_mul_a", {32'd0, mul_a}, 64'h0000_0000_7FFF_FFFF);
         check("hold_mul_b", {32'd0, mul_b}, 64'h0000_0000_8000_0000);
      end
      out_ready = 1'b1;
      wait_drain(100);

      // Randomized traffic with random back-pressure and enable gaps.
      rand_done = 1'b0;
      fork
         begin
            for (int k = 0; k < 40; k++) begin
               ra = pick_operand();
               rb = pick_operand();
               push(ra, rb, ref_mul(ra, rb));
               tick($urandom_range(0, 3));
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               out_ready = ($urandom_range(0, 1) == 1);
               enable = ($urandom_range(0, 7) != 0);
               tick(1);
            end
         end
      join
      out_ready = 1'b1;
      enable = 1'b1;
      wait_drain(2000);
      tick(3);
      check("final_busy", {63'd0, busy}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_booth_issue_ctrl
